multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that drives the existing 6-bit ALU op_code interface and consumes its zero flag.
- Sequences fetch/decode/execute/memory/writeback for the five supported instructions: ADDU, ADDIU, LW, SW, BEQ.
- Sits between the shared instruction/data memory port and the datapath muxes, register file, PC and ALU.
- Holds the instruction register. All other datapath registers live outside and are strobed by this block.

Parameters:
- RESET_ILLEGAL_STICKY, 1, when 1 the illegal flag holds until reset; when 0 it clears on the next FETCH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory handshake completion, sampled while mem_req=1
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- ir  out  32  latched instruction word
- ir_we  out  1  IR load strobe, for debug/trace
- mdr_we  out  1  memory data register load
- alu_op  out  6  ALU op_code
- alu_src_a  out  1  ALU A select: 0=PC, 1=rs data
- alu_src_b  out  2  ALU B select: 00=rt data, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm<<2
- alu_zero  in  1  ALU zero flag
- alu_out_we  out  1  ALUOut register load
- pc_we  out  1  PC load
- pc_src  out  1  PC source: 0=ALU result, 1=ALUOut
- reg_we  out  1  register file write
- reg_dst  out  1  destination select: 0=rt, 1=rd
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
- illegal  out  1  unsupported instruction seen
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, ir=0, illegal=0.
  - All strobes 0, alu_op=000000, all selects 0.
- Output style: all outputs are Moore-decoded from state, except the gated strobes noted below.
- IDLE: no outputs; goes to FETCH on the next edge. The first mem_req is therefore asserted in the cycle after reset release.
- FETCH:
  - Outputs: mem_req=1, iord=0, mem_we=0.
  - Stays in FETCH while mem_ready=0.
  - On mem_ready=1: ir<=mem_rdata; ir_we=1, pc_we=1, pc_src=0, alu_op=000000, src_a=0, src_b=01 (PC+4); go to DECODE.
- DECODE:
  - Outputs: alu_op=000000, src_a=0, src_b=11, alu_out_we=1 (branch target captured).
  - Next state from ir[31:26]:
    - 000000 with funct ir[5:0]=100001: EXEC_R
    - 001001: EXEC_I
    - 100011 or 101011: ADDR
    - 000100: BRANCH
    - anything else: illegal<=1, go to FETCH (instruction skipped).
- EXEC_R: alu_op=000000, src_a=1, src_b=00, alu_out_we=1; go to WB_ALU with reg_dst=1 latched by state.
- EXEC_I: alu_op=001001, src_a=1, src_b=10, alu_out_we=1; go to WB_ALU with reg_dst=0.
- WB_ALU: reg_we=1, mem_to_reg=0, reg_dst per origin (two encoded states WB_R/WB_I); go to FETCH.
- ADDR: alu_op=ir[31:26], src_a=1, src_b=10, alu_out_we=1; go to MEM_RD for 100011, MEM_WR for 101011.
- MEM_RD: mem_req=1, iord=1, mem_we=0; wait for mem_ready; on mem_ready, mdr_we=1, go to WB_MEM.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1; go to FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; wait for mem_ready; then go to FETCH.
- BRANCH:
  - Outputs: alu_op=000100, src_a=1, src_b=00.
  - pc_we=alu_zero (combinationally gated), pc_src=1.
  - Always goes to FETCH.
- Latency: ADDU/ADDIU/BEQ take 4/4/3 cycles; LW 5 and SW 4, each assuming zero-wait memory. Every mem_ready wait cycle adds 1.
- Handshake rules:
  - mem_req, iord and mem_we stay stable while waiting.
  - mem_ready is ignored when mem_req=0.
- Asynchronous reset mid-access drops mem_req immediately; no completion is expected.
- ir is unchanged outside FETCH completion.
- No two of reg_we, pc_we and mdr_we are asserted in the same state except FETCH (pc_we+ir_we).

Decomposition:
- Package mc_pkg holds:
  - opcode constants OP_RTYPE=000000, OP_ADDIU=001001, OP_LW=100011, OP_SW=101011, OP_BEQ=000100
  - FUNCT_ADDU=100001
  - the state enum (4-bit)
  - the SRC_B encodings
- One sub-module, mc_decode (combinational): maps ir opcode/funct to the next state after DECODE, plus the illegal flag.

Test Plan:
- Reset, then ADDU (0x00851021) with zero-wait memory -> mem_req at cycle 1; pc_we and ir_we at FETCH; reg_we=1 with reg_dst=1 exactly 4 cycles after fetch start; alu_op=000000 in EXEC.
- LW (0x8C820004) with mem_ready delayed 2 cycles on both accesses -> iord=0 then 1; mdr_we once; reg_we with mem_to_reg=1 at the final cycle; 9 cycles total.
- BEQ (0x10850003) with alu_zero=1 -> pc_we=1, pc_src=1 in BRANCH. Repeat with alu_zero=0 -> pc_we=0; both return to FETCH.
- SW (0xAC820008) -> alu_op=101011 in ADDR; mem_we=1, iord=1 held through 3 wait cycles; reg_we never asserted.
- Unsupported opcode 0x08000000 -> illegal=1 after DECODE, next FETCH proceeds; sticky until rst_n pulse.
- rst_n pulsed low during MEM_RD wait -> mem_req drops in the same cycle; state_dbg=IDLE; ir=0; FETCH one cycle after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states and
// ALU B-operand select codes.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;

  localparam logic [1:0] SRC_B_RT       = 2'b00;
  localparam logic [1:0] SRC_B_FOUR     = 2'b01;
  localparam logic [1:0] SRC_B_IMM      = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_R   = 4'd5,
    S_WB_I   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_WB_MEM = 4'd9,
    S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11
  } state_t;

endpackage

// File: rtl/mc_decode.sv
// Instruction decoder: selects the state that follows DECODE and flags
// anything outside the supported ADDU/ADDIU/LW/SW/BEQ set.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     next_state,
  output logic       illegal
);

  // NOTE: every output gets a default before the case so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    next_state = S_FETCH;
    illegal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FUNCT_ADDU) next_state = S_EXEC_R;
        else                     illegal    = 1'b1;
      end
      OP_ADDIU:     next_state = S_EXEC_I;
      OP_LW, OP_SW: next_state = S_ADDR;
      OP_BEQ:       next_state = S_BRANCH;
      default:      illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a five-instruction MIPS subset. Owns the
// instruction register; every other datapath register is strobed from here.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter bit RESET_ILLEGAL_STICKY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic [31:0] ir,
  output logic        ir_we,
  output logic        mdr_we,
  output logic [5:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  input  logic        alu_zero,
  output logic        alu_out_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [3:0]  state_dbg
);

  state_t state, next_state;
  state_t dec_next;
  logic   dec_illegal;

  mc_decode u_decode (
    .opcode     (ir[31:26]),
    .funct      (ir[5:0]),
    .next_state (dec_next),
    .illegal    (dec_illegal)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: ir is a single control register, not a memory array, so it is
  // cheap to reset and the trace port shows zero until the first fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ir <= '0;
    else if (ir_we) ir <= mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (state == S_DECODE && dec_illegal) begin
      illegal <= 1'b1;
    end else if (!RESET_ILLEGAL_STICKY && state == S_FETCH) begin
      illegal <= 1'b0;
    end
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    alu_op     = OP_RTYPE;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RT;
    alu_out_we = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively for every instruction.
        alu_src_b  = SRC_B_IMM_SHL2;
        alu_out_we = 1'b1;
        next_state = dec_next;
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_RT;
        alu_out_we = 1'b1;
        next_state = S_WB_R;
      end
      S_EXEC_I: begin
        alu_op     = OP_ADDIU;
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        alu_out_we = 1'b1;
        next_state = S_WB_I;
      end
      S_WB_R: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b1;
        next_state = S_FETCH;
      end
      S_WB_I: begin
        reg_we     = 1'b1;
        next_state = S_FETCH;
      end
      S_ADDR: begin
        alu_op     = ir[31:26];
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        alu_out_we = 1'b1;
        next_state = (ir[31:26] == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          mdr_we     = 1'b1;
          next_state = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_op     = OP_BEQ;
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_RT;
        pc_we      = alu_zero;
        pc_src     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-cycle expected outputs are
// queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, iord;
  logic [31:0] ir;
  logic        ir_we, mdr_we;
  logic [5:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        alu_zero;
  logic        alu_out_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg;
  logic        illegal;
  logic [3:0]  state_dbg;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_ILLEGAL_STICKY(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir         (ir),
    .ir_we      (ir_we),
    .mdr_we     (mdr_we),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_zero   (alu_zero),
    .alu_out_we (alu_out_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .state_dbg  (state_dbg)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        mem_req, mem_we, iord, ir_we, mdr_we;
    logic [5:0]  alu_op;
    logic        src_a;
    logic [1:0]  src_b;
    logic        alu_out_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg;
    logic        illegal;
    logic [31:0] ir;
  } out_t;

  typedef struct {
    logic        ready;
    logic        zero;
    logic [31:0] rdata;
    out_t        exp;
  } vec_t;

  localparam logic [31:0] I_ADDU  = 32'h00851021;
  localparam logic [31:0] I_ADDIU = 32'h24820005;
  localparam logic [31:0] I_LW    = 32'h8C820004;
  localparam logic [31:0] I_SW    = 32'hAC820008;
  localparam logic [31:0] I_BEQ   = 32'h10850003;
  localparam logic [31:0] I_BAD   = 32'h08000000;
  localparam logic [31:0] G       = 32'hDEADBEEF;

  int   total = 0;
  int   bad   = 0;
  out_t sb[$];
  int   id_q[$];
  vec_t tbl[$];
  int   row_id = 0;

  // m = {mem_req, mem_we, iord, ir_we, mdr_we}
  // c = {alu_out_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg}
  function automatic out_t o(state_t st, logic [4:0] m, logic [5:0] op,
                             logic a, logic [1:0] b, logic [5:0] c);
    out_t r;
    r.st = st;
    {r.mem_req, r.mem_we, r.iord, r.ir_we, r.mdr_we} = m;
    r.alu_op = op;
    r.src_a  = a;
    r.src_b  = b;
    {r.alu_out_we, r.pc_we, r.pc_src, r.reg_we, r.reg_dst, r.mem_to_reg} = c;
    r.illegal = 1'b0;
    r.ir      = '0;
    return r;
  endfunction

  function automatic out_t sample();
    out_t r;
    r.st = state_dbg;
    {r.mem_req, r.mem_we, r.iord, r.ir_we, r.mdr_we} = {mem_req, mem_we, iord, ir_we, mdr_we};
    r.alu_op = alu_op;
    r.src_a  = alu_src_a;
    r.src_b  = alu_src_b;
    {r.alu_out_we, r.pc_we, r.pc_src, r.reg_we, r.reg_dst, r.mem_to_reg} =
      {alu_out_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg};
    r.illegal = illegal;
    r.ir      = ir;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic add(input logic rdy, input logic z, input logic [31:0] rd,
                     input out_t base, input logic [31:0] irv, input logic ill);
    vec_t v;
    v.ready = rdy;
    v.zero  = z;
    v.rdata = rd;
    v.exp   = base;
    v.exp.ir = irv;
    v.exp.illegal = ill;
    tbl.push_back(v);
  endtask

  // Driver: apply one row's inputs just after the rising edge and queue its
  // expected outputs; the checker below consumes them on the falling edge.
  task automatic drive(input vec_t v);
    mem_ready = v.ready;
    alu_zero  = v.zero;
    mem_rdata = v.rdata;
    sb.push_back(v.exp);
    id_q.push_back(row_id);
    row_id++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      out_t e, a;
      int   id;
      e  = sb.pop_front();
      id = id_q.pop_front();
      a  = sample();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL row%0d outputs: got %h want %h", id, a, e);
      end
    end
  end

  initial begin
    out_t rst_o, idl, fwt, fgo, dec, exr, exi, wbr, wbi, adl, ads, mrw, mrg, wbm, mww, brt, brn;
    vec_t v;

    idl = o(S_IDLE,   5'b00000, 6'b000000, 1'b0, 2'b00, 6'b000000);
    rst_o = idl;
    fwt = o(S_FETCH,  5'b10000, 6'b000000, 1'b0, 2'b01, 6'b000000);
    fgo = o(S_FETCH,  5'b10010, 6'b000000, 1'b0, 2'b01, 6'b010000);
    dec = o(S_DECODE, 5'b00000, 6'b000000, 1'b0, 2'b11, 6'b100000);
    exr = o(S_EXEC_R, 5'b00000, 6'b000000, 1'b1, 2'b00, 6'b100000);
    exi = o(S_EXEC_I, 5'b00000, 6'b001001, 1'b1, 2'b10, 6'b100000);
    wbr = o(S_WB_R,   5'b00000, 6'b000000, 1'b0, 2'b00, 6'b000110);
    wbi = o(S_WB_I,   5'b00000, 6'b000000, 1'b0, 2'b00, 6'b000100);
    adl = o(S_ADDR,   5'b00000, 6'b100011, 1'b1, 2'b10, 6'b100000);
    ads = o(S_ADDR,   5'b00000, 6'b101011, 1'b1, 2'b10, 6'b100000);
    mrw = o(S_MEM_RD, 5'b10100, 6'b000000, 1'b0, 2'b00, 6'b000000);
    mrg = o(S_MEM_RD, 5'b10101, 6'b000000, 1'b0, 2'b00, 6'b000000);
    wbm = o(S_WB_MEM, 5'b00000, 6'b000000, 1'b0, 2'b00, 6'b000101);
    mww = o(S_MEM_WR, 5'b11100, 6'b000000, 1'b0, 2'b00, 6'b000000);
    brt = o(S_BRANCH, 5'b00000, 6'b000100, 1'b1, 2'b00, 6'b011000);
    brn = o(S_BRANCH, 5'b00000, 6'b000100, 1'b1, 2'b00, 6'b001000);

    // ready=1 outside memory states checks that mem_ready is ignored there.
    add(1, 0, G, idl, 32'h0, 0);
    add(1, 0, I_ADDU, fgo, 32'h0, 0);
    add(1, 0, G, dec, I_ADDU, 0);
    add(1, 0, G, exr, I_ADDU, 0);
    add(1, 0, G, wbr, I_ADDU, 0);
    add(1, 0, I_ADDIU, fgo, I_ADDU, 0);
    add(1, 0, G, dec, I_ADDIU, 0);
    add(1, 0, G, exi, I_ADDIU, 0);
    add(1, 0, G, wbi, I_ADDIU, 0);
    // LW, two wait cycles on both accesses: 9 cycles
    add(0, 0, I_LW, fwt, I_ADDIU, 0);
    add(0, 0, I_LW, fwt, I_ADDIU, 0);
    add(1, 0, I_LW, fgo, I_ADDIU, 0);
    add(1, 0, G, dec, I_LW, 0);
    add(1, 0, G, adl, I_LW, 0);
    add(0, 0, G, mrw, I_LW, 0);
    add(0, 0, G, mrw, I_LW, 0);
    add(1, 0, 32'h12345678, mrg, I_LW, 0);
    add(1, 0, G, wbm, I_LW, 0);
    // SW, three wait cycles
    add(1, 0, I_SW, fgo, I_LW, 0);
    add(1, 0, G, dec, I_SW, 0);
    add(1, 0, G, ads, I_SW, 0);
    add(0, 0, G, mww, I_SW, 0);
    add(0, 0, G, mww, I_SW, 0);
    add(0, 0, G, mww, I_SW, 0);
    add(1, 0, G, mww, I_SW, 0);
    // BEQ taken then not taken
    add(1, 0, I_BEQ, fgo, I_SW, 0);
    add(1, 0, G, dec, I_BEQ, 0);
    add(1, 1, G, brt, I_BEQ, 0);
    add(1, 0, I_BEQ, fgo, I_BEQ, 0);
    add(1, 1, G, dec, I_BEQ, 0);
    add(1, 0, G, brn, I_BEQ, 0);
    // unsupported opcode, skipped; flag stays set afterwards
    add(1, 0, I_BAD, fgo, I_BEQ, 0);
    add(1, 0, G, dec, I_BAD, 0);
    add(1, 0, I_ADDU, fgo, I_BAD, 1);
    add(1, 0, G, dec, I_ADDU, 1);
    add(1, 0, G, exr, I_ADDU, 1);
    add(1, 0, G, wbr, I_ADDU, 1);
    // LW parked in MEM_RD wait for the reset pulse below
    add(1, 0, I_LW, fgo, I_ADDU, 1);
    add(1, 0, G, dec, I_LW, 1);
    add(1, 0, G, adl, I_LW, 1);
    add(0, 0, G, mrw, I_LW, 1);

    rst_n = 1'b0;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    mem_rdata = G;
    @(posedge clk);
    #1;
    v.ready = 1'b1; v.zero = 1'b0; v.rdata = G; v.exp = rst_o;
    drive(v);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    // Still waiting in MEM_RD; assert reset asynchronously mid-cycle.
    check("mem_req_before_rst", {31'b0, mem_req}, 32'd1);
    check("iord_before_rst", {31'b0, iord}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mem_req_async_drop", {31'b0, mem_req}, 32'd0);
    check("state_async_idle", {28'b0, state_dbg}, 32'(S_IDLE));
    check("ir_async_clear", ir, 32'h0);
    check("illegal_async_clear", {31'b0, illegal}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v.ready = 1'b1; v.zero = 1'b0; v.rdata = G; v.exp = idl;
    drive(v);
    v.ready = 1'b0; v.rdata = I_ADDU; v.exp = fwt;
    drive(v);
    v.ready = 1'b1; v.exp = fgo;
    drive(v);
    v.exp = dec; v.exp.ir = I_ADDU; v.rdata = G;
    drive(v);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
